// File: rtl/disp_arbiter_if.sv
// Bus between the seven-segment display arbiter and its requesters.
// The requester side (master) drives the refresh tick, the request levels and
// the packed per-requester values. The arbiter side (slave) returns the
// one-hot grant, the owner index, busy and the value for the display controller.
interface disp_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  logic                 tick;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   data;
  logic [NREQ-1:0]      grant;
  logic [2:0]           owner;
  logic                 busy;
  logic [DW-1:0]        seg;

  modport master (output tick, req, data, input grant, owner, busy, seg);
  modport slave  (input tick, req, data, output grant, owner, busy, seg);
endinterface

// File: rtl/disp_arbiter.sv
// Round-robin arbiter sharing the display value bus among NREQ requesters.
// Each owner keeps the display for at least HOLD_TICKS refresh ticks unless it
// drops its request; after the hold expires it yields only if someone else
// is waiting. All outputs are registered.
// Optional feature: define ARB_PREEMPT_EN to make requester 0 high priority
// (it preempts any other owner and always wins idle arbitration).
module disp_arbiter #(
  parameter int NREQ       = 4,
  parameter int DW         = 16,
  parameter int HOLD_TICKS = 480,
  parameter int CW         = 9
) (
  input logic            clk,
  input logic            reset,
  disp_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state_q;
  logic [NREQ-1:0]   grant_q;
  logic [2:0]        owner_q;
  logic [2:0]        rr_ptr_q;
  logic              busy_q;
  logic [DW-1:0]     seg_q;
  logic [CW-1:0]     hold_q;
`ifdef ARB_PREEMPT_EN
  logic              preempted_q;
`endif

  // First requester set in r, searching start, start+1, ... modulo NREQ.
  function automatic logic [2:0] first_from(input logic [NREQ-1:0] r,
                                            input logic [2:0]      start);
    logic [2:0] res;
    logic       found;
    int         idx;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(start) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && r[idx]) begin
        res   = 3'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [2:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  logic [NREQ-1:0] others;
  logic            own_req;
  logic [2:0]      next_ptr;
  logic [2:0]      search_start;
  logic [2:0]      rot_win;
  logic [2:0]      idle_win;
  logic [DW-1:0]   own_data;

  // Arbitration candidates for the current cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    others       = bus.req & ~onehot(owner_q);
    own_req      = bus.req[owner_q];
    next_ptr     = (int'(owner_q) == NREQ - 1) ? 3'd0 : owner_q + 3'd1;
    search_start = next_ptr;
`ifdef ARB_PREEMPT_EN
    // After requester 0 finishes a preemption, resume the preempted owner first.
    if (preempted_q && owner_q == 3'd0) search_start = rr_ptr_q;
`endif
    rot_win      = first_from(others, search_start);
    idle_win     = first_from(bus.req, rr_ptr_q);
`ifdef ARB_PREEMPT_EN
    if (bus.req[0]) idle_win = 3'd0;
`endif
    own_data     = bus.data[owner_q*DW +: DW];
  end

  // Ownership FSM with registered grant, owner, busy, seg and hold counter.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: reset is asynchronous, so every register is cleared the moment reset falls.
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= 3'd0;
      rr_ptr_q <= 3'd0;
      busy_q   <= 1'b0;
      seg_q    <= '0;
      hold_q   <= '0;
`ifdef ARB_PREEMPT_EN
      preempted_q <= 1'b0;
`endif
    end else begin
      // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            grant_q <= onehot(idle_win);
            owner_q <= idle_win;
            busy_q  <= 1'b1;
            hold_q  <= CW'(HOLD_TICKS);
            state_q <= OWN;
          end
        end
        OWN: begin
          seg_q <= own_data;
`ifdef ARB_PREEMPT_EN
          if (bus.req[0] && owner_q != 3'd0) begin
            grant_q     <= onehot(3'd0);
            owner_q     <= 3'd0;
            hold_q      <= CW'(HOLD_TICKS);
            rr_ptr_q    <= own_req ? owner_q : next_ptr;
            preempted_q <= own_req;
          end else
`endif
          if (!own_req) begin
            rr_ptr_q <= search_start;
`ifdef ARB_PREEMPT_EN
            preempted_q <= 1'b0;
`endif
            if (|others) begin
              grant_q <= onehot(rot_win);
              owner_q <= rot_win;
              hold_q  <= CW'(HOLD_TICKS);
            end else begin
              grant_q <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (hold_q == '0) begin
            if (|others) begin
              rr_ptr_q <= search_start;
              grant_q  <= onehot(rot_win);
              owner_q  <= rot_win;
              hold_q   <= CW'(HOLD_TICKS);
`ifdef ARB_PREEMPT_EN
              preempted_q <= 1'b0;
`endif
            end
          end else if (bus.tick) begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
  assign bus.seg   = seg_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter (default build, preemption disabled).
// Directed vector table from reset, hand sequences for async reset and
// non-preemption, then randomized traffic against a behavioural model.
module tb_disp_arbiter;
  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int HOLD = 3;
  localparam int CW   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  disp_arbiter_if #(.NREQ(N), .DW(DW)) bus ();

  disp_arbiter #(.NREQ(N), .DW(DW), .HOLD_TICKS(HOLD), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: who owns the display, how many ticks of hold remain,
  // where the next idle search starts, and the value last shown.
  bit            m_busy;
  int            m_owner;
  int            m_hold;
  int            m_ptr;
  logic [DW-1:0] m_seg;

  function automatic int search(input logic [N-1:0] mask, input int start);
    for (int k = 0; k < N; k++)
      if (mask[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_hold = 0; m_ptr = 0; m_seg = '0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic t, input logic [N*DW-1:0] d);
    logic [N-1:0] waiting;
    if (!m_busy) begin
      if (r != 0) begin
        m_owner = search(r, m_ptr);
        m_busy  = 1;
        m_hold  = HOLD;
      end
    end else begin
      m_seg   = d[m_owner*DW +: DW];
      waiting = r;
      waiting[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        m_ptr = (m_owner + 1) % N;
        if (waiting != 0) begin
          m_owner = search(waiting, m_ptr);
          m_hold  = HOLD;
        end else begin
          m_busy = 0;
        end
      end else if (m_hold == 0) begin
        if (waiting != 0) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = search(waiting, m_ptr);
          m_hold  = HOLD;
        end
      end else if (t) begin
        m_hold = m_hold - 1;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, then sample at the falling edge.
  task automatic apply(input logic [N-1:0] r, input logic t, input logic [N*DW-1:0] d);
    bus.req  = r;
    bus.tick = t;
    bus.data = d;
    @(posedge clk);
    model_step(r, t, d);
    @(negedge clk);
  endtask

  task automatic compare_model(input string tag);
    logic [N-1:0] g;
    g = m_busy ? N'(1) << m_owner : '0;
    check({tag, ".grant"}, 32'(bus.grant), 32'(g));
    check({tag, ".owner"}, 32'(bus.owner), 32'(m_owner));
    check({tag, ".busy"},  32'(bus.busy),  32'(m_busy));
    check({tag, ".seg"},   32'(bus.seg),   32'(m_seg));
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic          tick;
    logic [N-1:0]  grant;
    logic [2:0]    owner;
    logic          busy;
    logic [DW-1:0] seg;
  } vec_t;

  vec_t tbl[22];
  localparam logic [N*DW-1:0] D = {16'h4444, 16'h3333, 16'h2222, 16'h1234};

  initial begin
    logic [N-1:0]      r;
    logic [N*DW-1:0]   d;

    // req, tick -> grant, owner, busy, seg (HOLD_TICKS = 3)
    tbl[0]  = '{4'b0001, 1'b0, 4'b0001, 3'd0, 1'b1, 16'h0000};
    tbl[1]  = '{4'b0001, 1'b0, 4'b0001, 3'd0, 1'b1, 16'h1234};
    tbl[2]  = '{4'b0011, 1'b1, 4'b0001, 3'd0, 1'b1, 16'h1234};
    tbl[3]  = '{4'b0011, 1'b1, 4'b0001, 3'd0, 1'b1, 16'h1234};
    tbl[4]  = '{4'b0011, 1'b1, 4'b0001, 3'd0, 1'b1, 16'h1234};
    tbl[5]  = '{4'b0011, 1'b0, 4'b0010, 3'd1, 1'b1, 16'h1234};
    tbl[6]  = '{4'b0011, 1'b0, 4'b0010, 3'd1, 1'b1, 16'h2222};
    tbl[7]  = '{4'b0001, 1'b1, 4'b0001, 3'd0, 1'b1, 16'h2222};
    tbl[8]  = '{4'b0001, 1'b1, 4'b0001, 3'd0, 1'b1, 16'h1234};
    tbl[9]  = '{4'b1001, 1'b1, 4'b0001, 3'd0, 1'b1, 16'h1234};
    tbl[10] = '{4'b1001, 1'b1, 4'b0001, 3'd0, 1'b1, 16'h1234};
    tbl[11] = '{4'b1001, 1'b0, 4'b1000, 3'd3, 1'b1, 16'h1234};
    tbl[12] = '{4'b1000, 1'b0, 4'b1000, 3'd3, 1'b1, 16'h4444};
    tbl[13] = '{4'b0000, 1'b0, 4'b0000, 3'd3, 1'b0, 16'h4444};
    tbl[14] = '{4'b0000, 1'b0, 4'b0000, 3'd3, 1'b0, 16'h4444};
    tbl[15] = '{4'b0110, 1'b0, 4'b0010, 3'd1, 1'b1, 16'h4444};
    tbl[16] = '{4'b0100, 1'b0, 4'b0100, 3'd2, 1'b1, 16'h2222};
    tbl[17] = '{4'b0100, 1'b0, 4'b0100, 3'd2, 1'b1, 16'h3333};
    tbl[18] = '{4'b0000, 1'b0, 4'b0000, 3'd2, 1'b0, 16'h3333};
    tbl[19] = '{4'b1111, 1'b0, 4'b1000, 3'd3, 1'b1, 16'h3333};
    tbl[20] = '{4'b0000, 1'b0, 4'b0000, 3'd3, 1'b0, 16'h4444};
    tbl[21] = '{4'b1111, 1'b0, 4'b0001, 3'd0, 1'b1, 16'h4444};

    reset    = 1'b0;
    bus.req  = '0;
    bus.tick = 1'b0;
    bus.data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset.grant", 32'(bus.grant), 32'h0);
    check("reset.owner", 32'(bus.owner), 32'h0);
    check("reset.busy",  32'(bus.busy),  32'h0);
    check("reset.seg",   32'(bus.seg),   32'h0);
    reset = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].req, tbl[i].tick, D);
      check($sformatf("vec%0d.grant", i), 32'(bus.grant), 32'(tbl[i].grant));
      check($sformatf("vec%0d.owner", i), 32'(bus.owner), 32'(tbl[i].owner));
      check($sformatf("vec%0d.busy",  i), 32'(bus.busy),  32'(tbl[i].busy));
      check($sformatf("vec%0d.seg",   i), 32'(bus.seg),   32'(tbl[i].seg));
    end

    // Reset pulse mid-hold clears outputs without waiting for a clock edge.
    #2 reset = 1'b0;
    #1;
    check("async_rst.grant", 32'(bus.grant), 32'h0);
    check("async_rst.owner", 32'(bus.owner), 32'h0);
    check("async_rst.busy",  32'(bus.busy),  32'h0);
    check("async_rst.seg",   32'(bus.seg),   32'h0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // Without preemption, a new req[0] waits for owner 3's hold to expire.
    apply(4'b1000, 1'b0, D);
    check("nopre.first", 32'(bus.grant), 32'b1000);
    apply(4'b1000, 1'b0, D);
    for (int i = 0; i < 4; i++) begin
      apply(4'b1001, 1'b0, D);
      check($sformatf("nopre.wait%0d", i), 32'(bus.grant), 32'b1000);
    end
    for (int i = 0; i < 3; i++) begin
      apply(4'b1001, 1'b1, D);
      check($sformatf("nopre.tick%0d", i), 32'(bus.grant), 32'b1000);
    end
    apply(4'b1001, 1'b0, D);
    check("nopre.expire", 32'(bus.grant), 32'b0001);
    check("nopre.seg",    32'(bus.seg),   32'h4444);
    compare_model("nopre.model");

    // Randomized traffic against the model.
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
      d = {$urandom, $urandom};
      apply(r, ($urandom_range(0, 2) == 0), d);
      compare_model($sformatf("rand%0d", i));
      check($sformatf("rand%0d.onehot", i), 32'($onehot0(bus.grant)), 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
